// File: rtl/fetch_unit.sv
// Instruction fetch: 32-bit memory reads split into 16-bit instructions in a DEPTH-entry prefetch queue.
// Latency: queue head is combinational; best case 2 cycles from request to o_valid.
// Backpressure: no request while the queue lacks room; i_ready=0 holds the head.
// Optional feature macro: FETCH_FAULT_EN (misaligned-jump fault, sticky until reset).
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_jump,
  input  logic [31:0] i_jump_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_ir,
  output logic [31:0] o_pc,
  output logic        o_fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [47:0]   ent_q [DEPTH];
  logic [47:0]   ent_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic          skip_q, skip_d;
  logic [31:0]   pend_q, pend_d;
  logic          fault_q, fault_d;

  logic          pop;
  logic          jump_fault;
  logic [1:0]    npush;
  logic [AW+1:0] free_after, need;
  logic [31:0]   jump_tgt;

`ifdef FETCH_FAULT_EN
  assign jump_fault = i_jump & i_jump_pc[0];
`else
  logic unused_jump_lsb;
  assign unused_jump_lsb = i_jump_pc[0];
  assign jump_fault      = 1'b0;
`endif

  assign jump_tgt = {i_jump_pc[31:1], 1'b0};
  assign pop      = (count_q != '0) && i_ready;

  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    req_d      = req_q;
    addr_d     = addr_q;
    skip_d     = skip_q;
    pend_d     = pend_q;
    fault_d    = fault_q | jump_fault;
    npush      = 2'd0;
    free_after = (AW+2)'(DEPTH) - (AW+2)'(count_q) + (AW+2)'(pop);
    need       = skip_q ? (AW+2)'(1) : (AW+2)'(2);

    case (state_q)
      IDLE: begin
        if (i_jump) begin
          addr_d = {jump_tgt[31:2], 2'b00};
          skip_d = jump_tgt[1];
        end else if (!fault_q && free_after >= need) begin
          state_d = WAIT;
          req_d   = 1'b1;
        end
      end
      WAIT: begin
        if (i_jump && i_mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          addr_d  = {jump_tgt[31:2], 2'b00};
          skip_d  = jump_tgt[1];
        end else if (i_jump) begin
          // Address must stay stable until the stale read completes.
          state_d = DISCARD;
          pend_d  = jump_tgt;
        end else if (i_mem_ack) begin
          if (skip_q) begin
            ent_d[wr_ptr_q] = {i_mem_data[31:16], addr_q[31:2], 2'b10};
            npush           = 2'd1;
          end else begin
            ent_d[wr_ptr_q]          = {i_mem_data[15:0],  addr_q[31:2], 2'b00};
            ent_d[wr_ptr_q + AW'(1)] = {i_mem_data[31:16], addr_q[31:2], 2'b10};
            npush                    = 2'd2;
          end
          state_d = IDLE;
          req_d   = 1'b0;
          skip_d  = 1'b0;
          addr_d  = addr_q + 32'd4;
        end
      end
      DISCARD: begin
        if (i_mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          addr_d  = i_jump ? {jump_tgt[31:2], 2'b00} : {pend_q[31:2], 2'b00};
          skip_d  = i_jump ? jump_tgt[1] : pend_q[1];
        end else if (i_jump) begin
          pend_d = jump_tgt;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_jump) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(npush);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(npush) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      addr_q   <= {RESET_PC[31:2], 2'b00};
      skip_q   <= RESET_PC[1];
      pend_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      skip_q   <= skip_d;
      pend_q   <= pend_d;
      fault_q  <= fault_d;
    end
  end

  // Payload storage needs no reset: o_valid gates it.
  always_ff @(posedge i_clk) begin
    ent_q <= ent_d;
  end

  assign o_valid    = (count_q != '0);
  assign o_ir       = ent_q[rd_ptr_q][47:32];
  assign o_pc       = ent_q[rd_ptr_q][31:0];
  assign o_mem_req  = req_q;
  assign o_mem_addr = addr_q;
`ifdef FETCH_FAULT_EN
  assign o_fault    = fault_q;
`else
  assign o_fault    = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the dispatcher/control path and replaces the standalone instruction ROM.
- Reads 32-bit words from the shared memory port and splits each into two 16-bit instructions.
- Buffers the instructions in a small prefetch queue and presents one instruction at a time, with its PC, to decode.
- Accepts jump redirects from control, flushing the queue and discarding any in-flight stale fetch.

Parameters:
- DEPTH, 4: prefetch queue entries, 16 bits each; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: first fetch PC after reset; must be halfword aligned.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous reset, active-low; sampled on the rising edge of i_clk.
- i_jump  in  1  redirect request from control; single-cycle pulse.
- i_jump_pc  in  32  redirect target; bit1 selects the halfword.
- o_mem_req  out  1  memory read request.
- o_mem_addr  out  32  word address; bits [1:0] are always 0.
- i_mem_ack  in  1  read data valid; completes the outstanding request.
- i_mem_data  in  32  read data; [15:0] is the instruction at addr, [31:16] the one at addr+2.
- o_valid  out  1  o_ir/o_pc valid.
- i_ready  in  1  decode accepts the instruction this cycle.
- o_ir  out  16  instruction at the queue head.
- o_pc  out  32  PC of the o_ir instruction.
- o_fault  out  1  misaligned jump fault; only with FETCH_FAULT_EN, otherwise tied to 0.

Behaviour:
- Reset (i_rst==0 at an edge): queue empty, o_valid=0, o_mem_req=0, o_mem_addr=RESET_PC&~3, skip=RESET_PC[1], FSM=IDLE, o_fault=0. o_ir and o_pc are don't-care while o_valid=0.
- Reset asserted mid-operation drops the queue and any outstanding request. Memory must tolerate an abandoned request.
- Queue entries hold {ir, pc}. o_valid=(count!=0). The head is combinational, with no extra latency.
- A pop occurs when o_valid&&i_ready.
- Fetch FSM states: IDLE, WAIT, DISCARD.
  - IDLE -> WAIT: when free slots >= (skip ? 1 : 2), counting slots freed by a pop in the same cycle. o_mem_req rises on that edge.
  - WAIT: o_mem_req and o_mem_addr are held stable until i_mem_ack.
  - WAIT, on ack: push [31:16] only if skip=1, otherwise push [15:0] then [31:16]. Then clear skip, set o_mem_addr+=4 (mod 2^32), go to IDLE. o_mem_req=0 for at least one cycle between requests.
  - DISCARD: the request is still held. On ack, drop the data and go to IDLE; no push happens.
- Pushed PCs: {o_mem_addr[31:2],2'b00} and {o_mem_addr[31:2],2'b10}. They wrap through 32'hFFFF_FFFE to 0.
- Ack latency: minimum 1 cycle after the request edge. Best-case request-to-o_valid is 2 cycles.
- Jump (i_jump=1), at that edge:
  - Queue is flushed, so o_valid=0 the next cycle. A same-cycle pop has no further effect.
  - o_mem_addr becomes i_jump_pc&~3 and skip becomes i_jump_pc[1].
  - From WAIT: go to DISCARD, but o_mem_addr must stay stable. The target is latched in a pending register and loaded into o_mem_addr on the discard ack.
  - From DISCARD: the pending target is overwritten.
  - From IDLE: the new request may issue on the next edge.
  - A jump in the same cycle as an ack: the ack data is discarded, the FSM goes to IDLE, and the target is loaded.
- Full queue: no request is issued. Empty queue: o_valid=0, and i_ready is ignored.

Optional Feature:
- Macro: FETCH_FAULT_EN.
- Defined:
  - A jump with i_jump_pc[0]==1 sets o_fault (sticky until reset).
  - The queue is flushed and no further requests issue. An outstanding request is still drained via DISCARD.
  - o_valid stays 0.
- Undefined: i_jump_pc[0] is ignored (treated as 0) and o_fault is tied to 0.

Test Plan:
- Reset:
  - Stimulus: hold i_rst=0 for 3 cycles with RESET_PC=0.
  - Required: o_valid=0, o_mem_req=0, o_mem_addr=0.
  - Stimulus: release reset.
  - Required: request to addr 0 within 1 cycle.
- Sequential fetch:
  - Stimulus: memory returns 32'h2222_1111 @0 and 32'h4444_3333 @4, ack latency 1; i_ready=1.
  - Required: o_ir/o_pc sequence is 1111/0, 2222/2, 3333/4, 4444/6.
- Backpressure:
  - Stimulus: i_ready=0, DEPTH=4.
  - Required: after 2 acks the queue is full and o_mem_req stays 0.
  - Stimulus: pop 1 entry.
  - Required: still no request.
  - Stimulus: pop a 2nd entry.
  - Required: request to 8 issues.
- Odd-halfword jump:
  - Stimulus: i_jump with i_jump_pc=32'h102; memory @100 returns 32'hBBBB_AAAA.
  - Required: first output BBBB/102, then a request to 104.
- Jump during WAIT:
  - Stimulus: request @8 pending; i_jump to 32'h40; ack arrives 3 cycles later with 32'hDEAD_BEEF.
  - Required: that data is never output, o_mem_addr stays 8 until the ack, then the next request is to 40.
- Fault (FETCH_FAULT_EN):
  - Stimulus: i_jump_pc=32'h41.
  - Required: o_fault=1 next cycle, no further o_mem_req, o_valid stays 0.
  - Stimulus: assert reset.
  - Required: o_fault clears.
